// File: rtl/seqdet_pkg.sv
// Shared constants and state encoding for the 10110 detector and its
// window timer companion.
package seqdet_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_EXP_W = 8;

    localparam logic [1:0] ARM   = 2'b00;
    localparam logic [1:0] IDLE  = 2'b01;
    localparam logic [1:0] COUNT = 2'b10;

    typedef enum logic [1:0] {
        S_ARM   = ARM,
        S_IDLE  = IDLE,
        S_COUNT = COUNT
    } state_t;

endpackage

// File: rtl/window_timer_if.sv
// Detector-to-timer bundle: init/en/load_val in, co/busy/count/expiries
// back out.
interface window_timer_if
    import seqdet_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int EXP_W = DEF_EXP_W
) ();

    logic             init;
    logic             en;
    logic [WIDTH-1:0] load_val;
    logic             co;
    logic             busy;
    logic [WIDTH-1:0] count;
    logic [EXP_W-1:0] expiries;

    modport master (
        output init,
        output en,
        output load_val,
        input  co,
        input  busy,
        input  count,
        input  expiries
    );

    modport slave (
        input  init,
        input  en,
        input  load_val,
        output co,
        output busy,
        output count,
        output expiries
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/window_timer.sv
// Hold-off window after a detector match; co pulses re-arm the detector
// after reset and at the end of each window.
module window_timer
    import seqdet_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int EXP_W = DEF_EXP_W
) (
    input  logic           clk,
    input  logic           rst_n,
    window_timer_if.slave  bus
);

    state_t           state;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] ld;
    logic [EXP_W-1:0] exp_q;
    logic             co_q;
    logic             inc;
    logic             last;

    assign ld   = (bus.load_val == '0) ? WIDTH'(1) : bus.load_val;
    assign last = (count_q == WIDTH'(1));

    // Retrigger takes priority over expiry, so init masks the increment.
    assign inc = (state == S_COUNT) && !bus.init && bus.en && last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_ARM;
            count_q <= '0;
            co_q    <= 1'b0;
        end else begin
            co_q <= 1'b0;
            unique case (state)
                S_ARM: begin
                    co_q  <= 1'b1;
                    state <= S_IDLE;
                end
                S_IDLE: begin
                    if (bus.init) begin
                        count_q <= ld;
                        state   <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (bus.init) begin
                        count_q <= ld;
                    end else if (bus.en) begin
                        if (last) begin
                            count_q <= '0;
                            co_q    <= 1'b1;
                            state   <= S_IDLE;
                        end else if (count_q > WIDTH'(1)) begin
                            count_q <= count_q - WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state <= S_ARM;
                end
            endcase
        end
    end

    sat_counter #(
        .W (EXP_W)
    ) u_exp (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc),
        .q     (exp_q)
    );

    assign bus.co       = co_q;
    assign bus.busy     = (state == S_COUNT);
    assign bus.count    = count_q;
    assign bus.expiries = exp_q;

endmodule

// File: doc/window_timer.md
# window_timer

Downstream companion to the 10110 sequence detector. It consumes the detector's `init` and `en` outputs, runs a programmable hold-off window once a match is reported, and returns a one-cycle `co` pulse that re-arms the detector. It also issues the initial arming `co` pulse after reset and keeps a saturating count of completed windows for debug.

## Interface
- `WIDTH`, default 8: width of the window counter and `load_val`.
- `EXP_W`, default 8: width of the expiry counter.
- `clk`  in  1  rising-edge clock, shared with the detector.
- `rst_n`  in  1  synchronous, active-low reset, sampled on `clk` rise.
- `init`  in  1  start/retrigger request, driven from detector `init` (high while the detector is in the matched state).
- `en`  in  1  count enable, driven from detector `en`; a low level pauses the window.
- `load_val`  in  WIDTH  window length in enabled cycles; sampled only on an accepted `init`.
- `co`  out  1  registered one-cycle pulse; goes to detector `co`.
- `busy`  out  1  high while in COUNT; decoded from the state register.
- `count`  out  WIDTH  current remaining window count.
- `expiries`  out  EXP_W  number of completed windows, saturating.

## Operation
- States: ARM, IDLE, COUNT.
- ARM
  - Entered on reset.
  - First edge with `rst_n`=1: `co`<=1, next state IDLE.
  - `init` is ignored in ARM.
- IDLE
  - `co`<=0.
  - `init`=1: `count`<=max(`load_val`,1), next state COUNT. A `load_val` of 0 is treated as 1.
  - Otherwise hold.
- COUNT, evaluated in priority order:
  1. `init`=1 (retrigger): `count`<=max(`load_val`,1), stay in COUNT, `co`<=0.
  2. `en`=1 and `count`==1: `count`<=0, `co`<=1, `expiries`+=1 (saturating at all-ones), next state IDLE.
  3. `en`=1 and `count`>1: `count`<=`count`-1.
  4. `en`=0: hold `count`.
- `co` is high for exactly one cycle per expiry and per reset release; it is never high on two consecutive cycles.
- `count` arithmetic is unsigned WIDTH-bit with no wrap. Decrement only happens from a value of 2 or more.
- Reset mid-window: state ARM, `count`=0, `co`=0, `expiries`=0 on that edge; the window is discarded.

## Timing
- Reset values: `co`=0, `busy`=0, `count`=0, `expiries`=0, state ARM.
- Arming pulse: `co` is high during the first cycle after the first rising edge that samples `rst_n`=1.
- Latency:
  - Accepted `init` at edge k, `load_val`=N≥1, `en` high throughout: `co` rises at edge k+N and falls at edge k+N+1.
  - Each cycle with `en`=0 adds one cycle of latency.
- `init` and expiry in the same cycle (COUNT, `count`==1, `en`=1, `init`=1): retrigger wins. The window reloads, no `co` pulse, `expiries` is unchanged.
- `busy` rises the cycle after the accepted `init` edge and falls in the same cycle `co` rises.
- Only the `co`, `count` and `expiries` registers and the state register feed the outputs. No combinational path from inputs to outputs.

## Structure
- Shared package `seqdet_pkg`:
  - 2-bit state encoding localparams: ARM=2'b00, IDLE=2'b01, COUNT=2'b10.
  - Default `WIDTH` and `EXP_W` constants.
  - The detector adopts these constants as well.
- One sub-module: `sat_counter` (parameter `W`; ports `clk`, `rst_n`, `inc`, `q`). It implements `expiries` and saturates at 2^W−1.
- Everything else sits in a single always block plus output decode, roughly 150–200 lines.

## Test plan
- Reset release: hold `rst_n`=0 for 3 cycles, then release with `init`=0. Required: `co` high for exactly 1 cycle after the first released edge; `busy`=0, `count`=0, `expiries`=0.
- Basic window: `load_val`=5, `init` pulse at edge k, `en`=1. Required: `count` steps 5,4,3,2,1,0; `co` high only in cycle k+5; `expiries`=1; `busy` low after expiry.
- Pause: `load_val`=4, `en` low for 3 cycles mid-window. Required: `count` holds during the pause; `co` at k+7.
- Retrigger and collision:
  - `init` at k+2 during a 6-cycle window: `co` at k+8.
  - Separate run with `init` exactly on the `count`==1 cycle: no `co` pulse and a reload to `load_val`.
- Edge values:
  - `load_val`=0: behaves as 1, `co` at k+1.
  - Reset asserted mid-window with `count`=3: `count`=0, no `co`, `expiries` cleared; the arming pulse repeats on release.
- Saturation: with `EXP_W`=2, run 5 windows. Required: `expiries` reads 1,2,3,3,3.
